// File: rtl/image_data_put.sv
// Write-side frame buffer manager: rotates three SDRAM buffers, one burst per frame start.
// Latency: o_mem_start two cycles after the frame-start edge; commit registered on the done pulse.
// Backpressure: a single write outstanding; frame starts while busy are dropped and counted.
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_frame_start                frame-start level (rising edge triggers a write)
//   i_mem_addrs0/1/2             base addresses of the three buffers
//   i_mem_done                   completion pulse from the write engine
//   o_mem_start, o_mem_addrs     write request pulse and target base address
//   o_data_length                constant burst length in pixels
//   o_mem_cnt                    published rotation counter (reader picks the last completed buffer)
//   o_frame_done, o_err          commit pulse, watchdog timeout pulse
//   o_drop_cnt                   saturating count of dropped frame starts
module image_data_put #(
    parameter int SDRAM_ADDRS_DW    = 21,
    parameter int IMAGE_WIDE_LENGTH = 256,
    parameter int IMAGE_HIGH_LENGTH = 192,
    parameter int TIMEOUT_CYCLES    = 1048576
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_frame_start,
    input  logic [SDRAM_ADDRS_DW-1:0] i_mem_addrs0,
    input  logic [SDRAM_ADDRS_DW-1:0] i_mem_addrs1,
    input  logic [SDRAM_ADDRS_DW-1:0] i_mem_addrs2,
    input  logic                      i_mem_done,
    output logic                      o_mem_start,
    output logic [SDRAM_ADDRS_DW-1:0] o_mem_addrs,
    output logic [31:0]               o_data_length,
    output logic [1:0]                o_mem_cnt,
    output logic                      o_frame_done,
    output logic                      o_err,
    output logic [7:0]                o_drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [23:0] WDOG_LAST = 24'(TIMEOUT_CYCLES - 1);

    state_t                    state, state_nxt;
    logic [1:0]                start_dly;
    logic [1:0]                wr_idx, wr_idx_nxt, wr_idx_inc;
    logic [23:0]               wdog, wdog_nxt;
    logic [SDRAM_ADDRS_DW-1:0] addr_sel, mem_addrs_nxt;
    logic                      mem_start_nxt, frame_done_nxt, err_nxt;
    logic [1:0]                mem_cnt_nxt;
    logic [7:0]                drop_cnt_nxt;
    logic                      start_evt;

    assign o_data_length = 32'(IMAGE_WIDE_LENGTH * IMAGE_HIGH_LENGTH);
    assign start_evt     = (start_dly == 2'b01);
    assign wr_idx_inc    = (wr_idx == 2'd2) ? 2'd0 : wr_idx + 2'd1;

    always_comb begin
        case (wr_idx)
            2'd1:    addr_sel = i_mem_addrs1;
            2'd2:    addr_sel = i_mem_addrs2;
            default: addr_sel = i_mem_addrs0;
        endcase
    end

    always_comb begin
        state_nxt      = state;
        wr_idx_nxt     = wr_idx;
        wdog_nxt       = wdog;
        mem_addrs_nxt  = o_mem_addrs;
        mem_start_nxt  = 1'b0;
        frame_done_nxt = 1'b0;
        err_nxt        = 1'b0;
        mem_cnt_nxt    = o_mem_cnt;
        drop_cnt_nxt   = o_drop_cnt;

        // Any frame start that lands while a write is in flight is discarded.
        if (start_evt && (state != S_IDLE) && (o_drop_cnt != 8'hFF))
            drop_cnt_nxt = o_drop_cnt + 8'd1;

        case (state)
            S_IDLE: begin
                if (start_evt) begin
                    mem_addrs_nxt = addr_sel;
                    wdog_nxt      = '0;
                    state_nxt     = S_REQ;
                end
            end
            S_REQ: begin
                mem_start_nxt = 1'b1;
                state_nxt     = S_WAIT;
            end
            S_WAIT: begin
                wdog_nxt = wdog + 24'd1;
                // Done is checked first so it wins over a coincident timeout.
                if (i_mem_done) begin
                    wr_idx_nxt     = wr_idx_inc;
                    mem_cnt_nxt    = wr_idx_inc;
                    frame_done_nxt = 1'b1;
                    state_nxt      = S_IDLE;
                end else if (wdog == WDOG_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= S_IDLE;
            start_dly    <= 2'b00;
            wr_idx       <= 2'd0;
            wdog         <= '0;
            o_mem_start  <= 1'b0;
            o_mem_addrs  <= '0;
            o_mem_cnt    <= 2'd0;
            o_frame_done <= 1'b0;
            o_err        <= 1'b0;
            o_drop_cnt   <= 8'd0;
        end else begin
            state        <= state_nxt;
            start_dly    <= {start_dly[0], i_frame_start};
            wr_idx       <= wr_idx_nxt;
            wdog         <= wdog_nxt;
            o_mem_start  <= mem_start_nxt;
            o_mem_addrs  <= mem_addrs_nxt;
            o_mem_cnt    <= mem_cnt_nxt;
            o_frame_done <= frame_done_nxt;
            o_err        <= err_nxt;
            o_drop_cnt   <= drop_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_image_data_put.sv
// Testbench for image_data_put: randomized frames against a buffer-rotation reference model.
// Latency: expected events are timestamped in cycles and checked by a decoupled monitor.
// Backpressure: extra frame starts are injected while a write is outstanding.
module tb_image_data_put;

    localparam int AW = 21;
    localparam int T  = 128;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_frame_start;
    logic [AW-1:0] i_mem_addrs0, i_mem_addrs1, i_mem_addrs2;
    logic          i_mem_done;
    logic          o_mem_start;
    logic [AW-1:0] o_mem_addrs;
    logic [31:0]   o_data_length;
    logic [1:0]    o_mem_cnt;
    logic          o_frame_done;
    logic          o_err;
    logic [7:0]    o_drop_cnt;

    image_data_put #(
        .SDRAM_ADDRS_DW   (AW),
        .IMAGE_WIDE_LENGTH(256),
        .IMAGE_HIGH_LENGTH(192),
        .TIMEOUT_CYCLES   (T)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_frame_start(i_frame_start),
        .i_mem_addrs0 (i_mem_addrs0),
        .i_mem_addrs1 (i_mem_addrs1),
        .i_mem_addrs2 (i_mem_addrs2),
        .i_mem_done   (i_mem_done),
        .o_mem_start  (o_mem_start),
        .o_mem_addrs  (o_mem_addrs),
        .o_data_length(o_data_length),
        .o_mem_cnt    (o_mem_cnt),
        .o_frame_done (o_frame_done),
        .o_err        (o_err),
        .o_drop_cnt   (o_drop_cnt)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int          cyc;
        logic [AW-1:0] addr;
    } st_e;

    typedef struct {
        int         cyc;
        bit         err;
        logic [1:0] cnt;
        logic [7:0] drops;
    } cm_e;

    st_e exp_st[$];
    cm_e exp_cm[$];

    // Reference model: which buffer is next, what the reader was last told, drops so far.
    int          k_next;
    int          pub;
    int          drops;
    bit          pre_started;
    logic [AW-1:0] last_addr;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int k);
        case (k)
            1:       return i_mem_addrs1;
            2:       return i_mem_addrs2;
            default: return i_mem_addrs0;
        endcase
    endfunction

    // Monitor: pops an expectation whenever the DUT presents a pulse.
    initial begin
        st_e s;
        cm_e m;
        forever begin
            @(negedge i_clk);
            if (o_mem_start) begin
                if (exp_st.size() == 0) chk("unexpected_start", 1, 0);
                else begin
                    s = exp_st.pop_front();
                    chk("start_cycle", 64'(cyc), 64'(s.cyc));
                    chk("start_addr", 64'(o_mem_addrs), 64'(s.addr));
                    last_addr = s.addr;
                end
            end
            if (o_frame_done || o_err) begin
                if (exp_cm.size() == 0) chk("unexpected_commit", {o_frame_done, o_err}, 0);
                else begin
                    m = exp_cm.pop_front();
                    chk("commit_cycle", 64'(cyc), 64'(m.cyc));
                    chk("commit_kind", {o_frame_done, o_err}, {!m.err, m.err});
                    chk("mem_cnt", 64'(o_mem_cnt), 64'(m.cnt));
                    chk("drop_cnt", 64'(o_drop_cnt), 64'(m.drops));
                    chk("addr_hold", 64'(o_mem_addrs), 64'(last_addr));
                end
            end
        end
    end

    // One accepted frame. d < T: done driven d cycles after o_mem_start is seen;
    // d >= T: no done (watchdog fires) and a late done is sent once idle.
    // nrise extra rising edges are attempted inside the busy window.
    // chain: the next frame's rising edge is placed so it is detected right after commit.
    task automatic do_frame(input int d, input int hold, input int nrise, input bit chain);
        int  n, endc, rises, cnt_r;
        bit  chained;
        if (!pre_started) begin
            @(negedge i_clk);
            i_mem_done    = 1'b0;
            i_frame_start = 1'b1;
        end
        n = cyc;
        pre_started = 1'b0;
        endc = (d < T) ? n + 4 + d : n + 3 + T;
        exp_st.push_back('{n + 3, addr_of(k_next)});

        cnt_r = 0;
        for (int c = n + hold + 1; c <= endc - 3 && cnt_r < nrise; c += 2) cnt_r++;
        drops = (drops + cnt_r > 255) ? 255 : drops + cnt_r;
        if (d < T) begin
            k_next = (k_next + 1) % 3;
            pub    = k_next;
        end
        exp_cm.push_back('{endc, d >= T, 2'(pub), 8'(drops)});

        rises   = 0;
        chained = 1'b0;
        for (int c = n + 1; c <= endc - 1; c++) begin
            @(negedge i_clk);
            i_mem_done = (d < T) && (c == n + 3 + d);
            if (c < n + hold)
                i_frame_start = 1'b1;
            else if (rises < nrise && ((c - n - hold) % 2 == 1) && c <= endc - 3) begin
                i_frame_start = 1'b1;
                rises++;
            end else
                i_frame_start = 1'b0;
            if (chain && d < T && c == endc - 1 && c >= n + hold + 1) begin
                i_frame_start = 1'b1;
                chained = 1'b1;
            end
        end
        if (chained) pre_started = 1'b1;
        else begin
            @(negedge i_clk);
            i_mem_done    = (d >= T);
            i_frame_start = 1'b0;
            @(negedge i_clk);
            i_mem_done = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_start"}, 64'(o_mem_start), 0);
        chk({tag, "_addrs"}, 64'(o_mem_addrs), 0);
        chk({tag, "_cnt"}, 64'(o_mem_cnt), 0);
        chk({tag, "_done"}, 64'(o_frame_done), 0);
        chk({tag, "_err"}, 64'(o_err), 0);
        chk({tag, "_drop"}, 64'(o_drop_cnt), 0);
    endtask

    initial begin
        int n;
        i_rst         = 1'b1;
        i_frame_start = 1'b0;
        i_mem_done    = 1'b0;
        i_mem_addrs0  = AW'($urandom);
        i_mem_addrs1  = AW'($urandom) ^ 21'h100000;
        i_mem_addrs2  = AW'($urandom) ^ 21'h0AAAAA;
        if (i_mem_addrs1 == i_mem_addrs0) i_mem_addrs1 = i_mem_addrs0 + 21'd1;
        if (i_mem_addrs2 == i_mem_addrs0 || i_mem_addrs2 == i_mem_addrs1)
            i_mem_addrs2 = i_mem_addrs1 + 21'd7;
        k_next = 0; pub = 0; drops = 0; pre_started = 1'b0; last_addr = '0;

        repeat (3) @(negedge i_clk);
        check_reset_outputs("reset");
        chk("data_length", 64'(o_data_length), 64'd49152);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);

        // Three frames plus a wrap back to buffer 0.
        for (int i = 0; i < 4; i++) do_frame(100, 2, 0, 1'b0);
        // Second rising edge during the write is dropped.
        do_frame(100, 2, 1, 1'b0);
        // Watchdog timeout, then the same buffer is rewritten.
        do_frame(T, 2, 0, 1'b0);
        do_frame(10, 2, 0, 1'b0);
        // Done while idle changes nothing.
        @(negedge i_clk); i_mem_done = 1'b1;
        @(negedge i_clk); i_mem_done = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("idle_done_cnt", 64'(o_mem_cnt), 64'(pub));
        // Start held high for 50 cycles gives exactly one request.
        do_frame(60, 50, 0, 1'b0);
        // Done coincident with the last watchdog cycle wins; zero-delay done.
        do_frame(T - 1, 2, 3, 1'b0);
        do_frame(0, 1, 0, 1'b1);
        do_frame(5, 1, 0, 1'b0);

        // Randomized phase; long enough for the drop counter to saturate.
        for (int i = 0; i < 150; i++) begin
            int d, h, r;
            d = ($urandom_range(0, 5) == 0) ? T : $urandom_range(0, T - 1);
            h = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 60) : $urandom_range(1, 3);
            r = $urandom_range(0, 30);
            do_frame(d, h, r, (i != 149) && ($urandom_range(0, 3) == 0));
        end
        repeat (3) @(negedge i_clk);
        chk("drop_saturated", 64'(o_drop_cnt), 64'(drops));

        // Reset in the middle of a write; a late done must be ignored.
        @(negedge i_clk);
        n = cyc;
        i_frame_start = 1'b1;
        exp_st.push_back('{n + 3, addr_of(k_next)});
        repeat (2) @(negedge i_clk);
        i_frame_start = 1'b0;
        repeat (10) @(negedge i_clk);
        #2 i_rst = 1'b1;
        #1 check_reset_outputs("midreset");
        @(negedge i_clk);
        i_rst = 1'b0;
        k_next = 0; pub = 0; drops = 0;
        @(negedge i_clk); i_mem_done = 1'b1;
        @(negedge i_clk); i_mem_done = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("late_done_ignored", {o_frame_done, o_mem_cnt}, 0);
        do_frame(20, 2, 0, 1'b0);

        repeat (4) @(negedge i_clk);
        chk("start_q_empty", 64'(exp_st.size()), 0);
        chk("commit_q_empty", 64'(exp_cm.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
